// File: rtl/board_pkg.sv
// board_pkg
//   Shared board geometry, cell encoding, LFSR constants, FSM state type and
//   the cell index helper used by the refill and eliminate logic.
//   A board is ROWS*COLS cells of CELL_W bits; cell (i,j) lives at
//   bits cell_idx(i,j) +: CELL_W, with i = row (0 top) and j = column.
package board_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int CELL_W  = 3;
  localparam int BOARD_W = ROWS * COLS * CELL_W;

  localparam logic [CELL_W-1:0] EMPTY = 3'd0;

  localparam int          LFSR_W    = 24;
  localparam logic [23:0] LFSR_SEED = 24'h5A5A5A;
  // Feedback taps for x^24 + x^23 + x^22 + x^17 + 1 (bits 23, 22, 21, 16).
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Bit offset of cell (i,j) inside a packed board vector.
  function automatic int cell_idx(input int i, input int j);
    return (i * COLS + j) * CELL_W;
  endfunction

endpackage

// File: rtl/board_refill_lfsr.sv
// refill_lfsr
//   24-bit Fibonacci LFSR that supplies the colors of newly dropped tiles.
//   It advances on every clock edge and reloads the nonzero seed on reset,
//   so it can never lock up in the all-zero state.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset (loads LFSR_SEED)
//   value out  current LFSR state
module refill_lfsr
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [23:0] value
);

  logic [23:0] value_q;
  logic [23:0] value_d;
  logic        feedback;

  // Next LFSR state: shift toward the MSB and insert the tap parity at bit 0.
  always_comb begin
    feedback = ^(value_q & LFSR_TAPS);
    value_d  = {value_q[22:0], feedback};
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/board_refill.sv
// board_refill
//   Lets the tiles of a board drop into empty cells and tops up every column
//   with new random colors, one row per clock per column, until no empty cell
//   remains.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   start       in   refill request, only honoured in IDLE
//   board_in    in   board after elimination (0 = empty cell)
//   board_out   out  settled board, valid while done = 1 and held afterwards
//   busy        out  high while a refill is in progress
//   done        out  one-cycle pulse once board_out is settled
//   fill_count  out  number of cells filled with new colors by the refill
module board_refill
  import board_pkg::*;
#(
  parameter int NUM_COLORS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] board_in,
  output logic [191:0] board_out,
  output logic         busy,
  output logic         done,
  output logic [6:0]   fill_count
);

  localparam logic [7:0] NUM_COLORS_8 = 8'(NUM_COLORS);

  // New color for column c: an 8-bit window of the LFSR folded into 1..NUM_COLORS.
  function automatic logic [2:0] new_color(input logic [23:0] lfsr, input int c);
    return 3'((lfsr[2*c +: 8] % NUM_COLORS_8) + 8'd1);
  endfunction

  function automatic logic col_has_empty(input logic [23:0] col);
    logic found;
    found = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (col[r*CELL_W +: CELL_W] == EMPTY) begin
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

  // One settle step for a column: everything above the lowest hole drops by
  // one row and the top row receives the new color. A full column is unchanged.
  function automatic logic [23:0] col_step(input logic [23:0] col, input logic [2:0] color);
    logic [23:0] res;
    int          k;
    logic        found;
    res   = col;
    k     = 0;
    found = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (col[r*CELL_W +: CELL_W] == EMPTY) begin
        k     = r;
        found = 1'b1;
      end else begin
        k = k;
      end
    end
    if (found) begin
      for (int r = 1; r < ROWS; r++) begin
        if (r <= k) begin
          res[r*CELL_W +: CELL_W] = col[(r-1)*CELL_W +: CELL_W];
        end else begin
          res[r*CELL_W +: CELL_W] = col[r*CELL_W +: CELL_W];
        end
      end
      res[CELL_W-1:0] = color;
    end else begin
      res = col;
    end
    return res;
  endfunction

  state_t         state_q, state_d;
  logic [191:0]   board_q, board_d;
  logic [6:0]     fill_q, fill_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic [23:0]    lfsr_value;

  logic [191:0]   stepped_board;
  logic           any_empty;
  logic [6:0]     step_count;
  logic [23:0]    col_cur;
  logic [23:0]    col_next;

  refill_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  // Candidate board after one parallel step of all columns, plus hole summary.
  always_comb begin
    stepped_board = board_q;
    any_empty     = 1'b0;
    step_count    = 7'd0;
    col_cur       = 24'd0;
    col_next      = 24'd0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        col_cur[r*CELL_W +: CELL_W] = board_q[cell_idx(r, c) +: CELL_W];
      end
      col_next = col_step(col_cur, new_color(lfsr_value, c));
      for (int r = 0; r < ROWS; r++) begin
        stepped_board[cell_idx(r, c) +: CELL_W] = col_next[r*CELL_W +: CELL_W];
      end
      if (col_has_empty(col_cur)) begin
        any_empty  = 1'b1;
        step_count = step_count + 7'd1;
      end else begin
        step_count = step_count;
      end
    end
  end

  // FSM next-state and datapath update.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          board_d = board_in;
          fill_d  = 7'd0;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!any_empty) begin
          state_d = ST_DONE;
        end else begin
          board_d = stepped_board;
          fill_d  = fill_q + step_count;
        end
      end
      ST_DONE: begin
        // done is registered from this state, so it shows in the following IDLE cycle.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      board_q <= 192'd0;
      fill_q  <= 7'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign board_out  = board_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_board_refill.sv
// tb_board_refill
//   Directed bench for board_refill with hand-computed expectations.
module tb_board_refill;

  logic         clk;
  logic         rst;
  logic         start;
  logic [191:0] board_in;
  logic [191:0] board_out;
  logic         busy;
  logic         done;
  logic [6:0]   fill_count;

  int total;
  int bad;

  board_refill #(.NUM_COLORS(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board_in   (board_in),
    .board_out  (board_out),
    .busy       (busy),
    .done       (done),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] fill_all(input logic [2:0] v);
    logic [191:0] b;
    for (int k = 0; k < 64; k++) b[k*3 +: 3] = v;
    return b;
  endfunction

  function automatic logic [191:0] set_cell(input logic [191:0] b, input int i, input int j,
                                            input logic [2:0] v);
    logic [191:0] r;
    r = b;
    r[(8*i+j)*3 +: 3] = v;
    return r;
  endfunction

  function automatic logic [2:0] get_cell(input logic [191:0] b, input int i, input int j);
    return b[(8*i+j)*3 +: 3];
  endfunction

  function automatic logic in_range(input logic [2:0] v);
    return (v >= 3'd1) && (v <= 3'd5);
  endfunction

  // Issue one start, optionally pulse start again during SETTLE, and measure
  // the number of edges from the accept edge to the done pulse (-1 = none).
  task automatic do_refill(input logic [191:0] b, input logic pulse_again, output int lat);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = pulse_again;
    check("busy_after_accept", {191'd0, busy}, 192'd1);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  int           lat;
  int           bad_cells;
  logic         seen;
  logic [191:0] exp_b;
  logic [191:0] got_b;
  logic [191:0] out1;

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    board_in = 192'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {191'd0, busy}, 192'd0);
    check("rst_done", {191'd0, done}, 192'd0);
    check("rst_board", board_out, 192'd0);
    check("rst_fill", {185'd0, fill_count}, 192'd0);
    rst = 1'b0;

    // Full board: nothing to do
    do_refill(fill_all(3'd1), 1'b0, lat);
    check("full_latency", 192'(lat), 192'd2);
    check("full_board", board_out, fill_all(3'd1));
    check("full_fill", {185'd0, fill_count}, 192'd0);
    @(negedge clk);
    check("full_done_pulse", {191'd0, done}, 192'd0);
    check("full_hold", board_out, fill_all(3'd1));

    // Single hole at the bottom of column 0
    do_refill(set_cell(fill_all(3'd2), 7, 0, 3'd0), 1'b0, lat);
    check("one_latency", 192'(lat), 192'd3);
    check("one_fill", {185'd0, fill_count}, 192'd1);
    check("one_new_range", {191'd0, in_range(get_cell(board_out, 0, 0))}, 192'd1);
    got_b = set_cell(board_out, 0, 0, 3'd0);
    exp_b = set_cell(fill_all(3'd2), 0, 0, 3'd0);
    check("one_board", got_b, exp_b);

    // Empty board: eight steps per column
    do_refill(192'd0, 1'b0, lat);
    check("empty_latency", 192'(lat), 192'd10);
    check("empty_fill", {185'd0, fill_count}, 192'd64);
    bad_cells = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (!in_range(get_cell(board_out, i, j))) bad_cells++;
    check("empty_cells_range", 192'(bad_cells), 192'd0);

    // Column 3 = 1,2,0,3,0,4,5,6 (top to bottom), others 1
    exp_b = fill_all(3'd1);
    exp_b = set_cell(exp_b, 1, 3, 3'd2);
    exp_b = set_cell(exp_b, 2, 3, 3'd0);
    exp_b = set_cell(exp_b, 3, 3, 3'd3);
    exp_b = set_cell(exp_b, 4, 3, 3'd0);
    exp_b = set_cell(exp_b, 5, 3, 3'd4);
    exp_b = set_cell(exp_b, 6, 3, 3'd5);
    exp_b = set_cell(exp_b, 7, 3, 3'd6);
    do_refill(exp_b, 1'b0, lat);
    check("col3_latency", 192'(lat), 192'd4);
    check("col3_fill", {185'd0, fill_count}, 192'd2);
    check("col3_b_range", {191'd0, in_range(get_cell(board_out, 0, 3))}, 192'd1);
    check("col3_a_range", {191'd0, in_range(get_cell(board_out, 1, 3))}, 192'd1);
    exp_b = fill_all(3'd1);
    exp_b = set_cell(exp_b, 0, 3, 3'd0);
    exp_b = set_cell(exp_b, 1, 3, 3'd0);
    exp_b = set_cell(exp_b, 2, 3, 3'd1);
    exp_b = set_cell(exp_b, 3, 3, 3'd2);
    exp_b = set_cell(exp_b, 4, 3, 3'd3);
    exp_b = set_cell(exp_b, 5, 3, 3'd4);
    exp_b = set_cell(exp_b, 6, 3, 3'd5);
    exp_b = set_cell(exp_b, 7, 3, 3'd6);
    got_b = set_cell(set_cell(board_out, 0, 3, 3'd0), 1, 3, 3'd0);
    check("col3_board", got_b, exp_b);

    // Start held high: a new refill begins on the IDLE cycle after DONE
    @(negedge clk);
    board_in = fill_all(3'd1);
    start    = 1'b1;
    seen     = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("held_first_done", {191'd0, seen}, 192'd1);
    @(negedge clk);
    check("held_rearm_busy", {191'd0, busy}, 192'd1);
    start = 1'b0;
    seen  = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("held_second_done", {191'd0, seen}, 192'd1);

    // Reset in the middle of SETTLE aborts without a done pulse
    @(negedge clk);
    board_in = 192'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {191'd0, busy}, 192'd0);
    check("abort_board", board_out, 192'd0);
    check("abort_fill", {185'd0, fill_count}, 192'd0);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", {191'd0, seen}, 192'd0);

    // Determinism, and a second start during SETTLE has no effect
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    do_refill(192'd0, 1'b0, lat);
    out1 = board_out;
    check("det_run1_latency", 192'(lat), 192'd10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    do_refill(192'd0, 1'b1, lat);
    check("det_run2_latency", 192'(lat), 192'd10);
    check("det_run2_fill", {185'd0, fill_count}, 192'd64);
    check("det_same_board", board_out, out1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
